// File: rtl/ex_mem_reg_pkg.sv
// ============================================================================
// ex_mem_reg_pkg : EX/MEM stage register state encodings and default widths.
// Revision 1.0
// ============================================================================
`default_nettype none

package ex_mem_reg_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_REG_W  = 5;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } exmem_state_t;

endpackage

`default_nettype wire

// File: rtl/ex_mem_reg_entry.sv
// ============================================================================
// exmem_entry : payload register with load enable and synchronous clear.
// Revision 1.0
// ============================================================================
`default_nettype none

module exmem_entry #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      r_q <= '0;
    end else if (load) begin
      r_q <= d;
    end
  end

  assign q = r_q;

endmodule

`default_nettype wire

// File: rtl/ex_mem_reg.sv
// ============================================================================
// ex_mem_reg : EX/MEM pipeline register as a 2-entry skid buffer with hazard
// detection. Forwarding outputs are live only when EXMEM_FORWARD_EN is defined.
// Revision 1.0
// ============================================================================
`default_nettype none

module ex_mem_reg
  import ex_mem_reg_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_W  = DEF_REG_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [DATA_W-1:0] ALUResult,
  input  logic [DATA_W-1:0] StoreData,
  input  logic [REG_W-1:0]  DestReg,
  input  logic              RegWrite,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              MemToReg,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [DATA_W-1:0] M_ALUResult,
  output logic [DATA_W-1:0] M_StoreData,
  output logic [REG_W-1:0]  M_DestReg,
  output logic              M_RegWrite,
  output logic              M_MemRead,
  output logic              M_MemWrite,
  output logic              M_MemToReg,
  input  logic              flush,
  input  logic [REG_W-1:0]  SrcA,
  input  logic [REG_W-1:0]  SrcB,
  output logic              FwdA,
  output logic              FwdB,
  output logic [DATA_W-1:0] FwdData,
  output logic              LoadUse
);

  localparam int PW = 2 * DATA_W + REG_W + 4;

  exmem_state_t r_state;
  exmem_state_t w_next;
  logic         r_ex_ready;
  logic         w_accept;
  logic         w_retire;
  logic         w_head_load;
  logic         w_skid_load;
  logic         w_head_from_skid;
  logic [PW-1:0] w_in;
  logic [PW-1:0] w_head_d;
  logic [PW-1:0] w_head_q;
  logic [PW-1:0] w_skid_q;

  assign w_in = {ALUResult, StoreData, DestReg, RegWrite, MemRead, MemWrite, MemToReg};

  assign mem_valid = (r_state != EMPTY);
  assign ex_ready  = r_ex_ready;
  assign w_accept  = ex_valid && r_ex_ready;
  assign w_retire  = mem_valid && mem_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_next;
    end
  end

  // ex_ready is registered from the next state so mem_ready never reaches it combinationally.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ex_ready <= 1'b1;
    end else begin
      r_ex_ready <= (w_next != TWO);
    end
  end

  always_comb begin
    w_next           = r_state;
    w_head_load      = 1'b0;
    w_skid_load      = 1'b0;
    w_head_from_skid = 1'b0;
    case (r_state)
      EMPTY: begin
        if (w_accept) begin
          w_next      = ONE;
          w_head_load = 1'b1;
        end
      end
      ONE: begin
        if (w_accept && !w_retire) begin
          w_next      = TWO;
          w_skid_load = 1'b1;
        end else if (!w_accept && w_retire) begin
          w_next = EMPTY;
        end else if (w_accept && w_retire) begin
          w_head_load = 1'b1;
        end
      end
      TWO: begin
        if (w_retire) begin
          w_next           = ONE;
          w_head_load      = 1'b1;
          w_head_from_skid = 1'b1;
        end
      end
      default: w_next = EMPTY;
    endcase
    if (flush) begin
      w_next      = EMPTY;
      w_head_load = 1'b0;
      w_skid_load = 1'b0;
    end
  end

  assign w_head_d = w_head_from_skid ? w_skid_q : w_in;

  exmem_entry #(.W(PW)) u_head (
    .clk   (clk),
    .reset (reset),
    .clr   (flush),
    .load  (w_head_load),
    .d     (w_head_d),
    .q     (w_head_q)
  );

  exmem_entry #(.W(PW)) u_skid (
    .clk   (clk),
    .reset (reset),
    .clr   (flush),
    .load  (w_skid_load),
    .d     (w_in),
    .q     (w_skid_q)
  );

  assign {M_ALUResult, M_StoreData, M_DestReg,
          M_RegWrite, M_MemRead, M_MemWrite, M_MemToReg} = w_head_q;

  assign LoadUse = mem_valid && M_MemRead && (M_DestReg != '0) &&
                   ((M_DestReg == SrcA) || (M_DestReg == SrcB));

`ifdef EXMEM_FORWARD_EN
  // Loads are excluded: their data is not known until MEM, which LoadUse covers.
  assign FwdA    = mem_valid && M_RegWrite && !M_MemRead &&
                   (M_DestReg != '0) && (M_DestReg == SrcA);
  assign FwdB    = mem_valid && M_RegWrite && !M_MemRead &&
                   (M_DestReg != '0) && (M_DestReg == SrcB);
  assign FwdData = M_ALUResult;
`else
  assign FwdA    = 1'b0;
  assign FwdB    = 1'b0;
  assign FwdData = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ex_mem_reg.sv
// ============================================================================
// tb_ex_mem_reg : self-checking bench for ex_mem_reg (directed + random/queue model).
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_ex_mem_reg;

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] sd;
    logic [4:0]  dst;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        m2r;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset, ex_valid, ex_ready, mem_valid, mem_ready, flush;
  logic [31:0] ALUResult, StoreData, M_ALUResult, M_StoreData, FwdData;
  logic [4:0]  DestReg, M_DestReg, SrcA, SrcB;
  logic        RegWrite, MemRead, MemWrite, MemToReg;
  logic        M_RegWrite, M_MemRead, M_MemWrite, M_MemToReg;
  logic        FwdA, FwdB, LoadUse;

  int passed = 0;
  int total  = 0;
`ifdef EXMEM_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  ex_mem_reg dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ALUResult(ALUResult), .StoreData(StoreData), .DestReg(DestReg),
    .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite), .MemToReg(MemToReg),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .M_ALUResult(M_ALUResult), .M_StoreData(M_StoreData), .M_DestReg(M_DestReg),
    .M_RegWrite(M_RegWrite), .M_MemRead(M_MemRead), .M_MemWrite(M_MemWrite),
    .M_MemToReg(M_MemToReg), .flush(flush), .SrcA(SrcA), .SrcB(SrcB),
    .FwdA(FwdA), .FwdB(FwdB), .FwdData(FwdData), .LoadUse(LoadUse)
  );

  always #5 clk = ~clk;

  task automatic set_in(input logic v, input ent_t e);
    ex_valid  = v;
    ALUResult = e.alu;
    StoreData = e.sd;
    DestReg   = e.dst;
    RegWrite  = e.rw;
    MemRead   = e.mr;
    MemWrite  = e.mw;
    MemToReg  = e.m2r;
  endtask

  function automatic ent_t mk(input logic [31:0] alu, input logic [4:0] dst,
                              input logic rw, input logic mr);
    ent_t e;
    e.alu = alu; e.sd = ~alu; e.dst = dst; e.rw = rw; e.mr = mr; e.mw = 1'b0; e.m2r = mr;
    return e;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; flush = 1'b0; mem_ready = 1'b0; SrcA = '0; SrcB = '0;
    set_in(1'b0, '0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1; mem_ready = 1'b1;
    set_in(1'b1, mk(32'hDEAD_BEEF, 5'd9, 1'b1, 1'b1));
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0; set_in(1'b0, '0); SrcA = 5'd9; SrcB = 5'd9;
    #1;
    total++; if (mem_valid !== 1'b0) $display("FAIL reset_mem_valid: got %b want 0", mem_valid); else passed++;
    total++; if (ex_ready !== 1'b1) $display("FAIL reset_ex_ready: got %b want 1", ex_ready); else passed++;
    total++; if (M_ALUResult !== 32'h0) $display("FAIL reset_alu: got %h want 0", M_ALUResult); else passed++;
    total++; if (M_DestReg !== 5'd0) $display("FAIL reset_dest: got %0d want 0", M_DestReg); else passed++;
    total++; if ({LoadUse, FwdA, FwdB} !== 3'b000 || FwdData !== 32'h0)
      $display("FAIL reset_hazard: got lu/fa/fb=%b%b%b fd=%h want 000/0", LoadUse, FwdA, FwdB, FwdData);
    else passed++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    mem_ready = 1'b1;
    set_in(1'b1, mk(32'h0000_0005, 5'd3, 1'b1, 1'b0));
    @(negedge clk);
    total++; if (mem_valid !== 1'b1 || M_ALUResult !== 32'h5 || M_DestReg !== 5'd3)
      $display("FAIL b2b_first: got v=%b %h d=%0d want 1 00000005 d=3", mem_valid, M_ALUResult, M_DestReg);
    else passed++;
    set_in(1'b1, mk(32'hFFFF_FFFF, 5'd4, 1'b1, 1'b0));
    @(negedge clk);
    total++; if (mem_valid !== 1'b1 || M_ALUResult !== 32'hFFFF_FFFF || M_DestReg !== 5'd4)
      $display("FAIL b2b_second: got v=%b %h d=%0d want 1 ffffffff d=4", mem_valid, M_ALUResult, M_DestReg);
    else passed++;
    total++; if (ex_ready !== 1'b1) $display("FAIL b2b_ready: got %b want 1", ex_ready); else passed++;
    set_in(1'b0, '0);
    @(negedge clk);
    total++; if (mem_valid !== 1'b0) $display("FAIL b2b_drain: got %b want 0", mem_valid); else passed++;
  endtask

  task automatic test_skid();
    do_reset();
    mem_ready = 1'b0;
    set_in(1'b1, mk(32'hA, 5'd1, 1'b1, 1'b0));
    @(negedge clk);
    set_in(1'b1, mk(32'hB, 5'd2, 1'b1, 1'b0));
    @(negedge clk);
    set_in(1'b1, mk(32'hC, 5'd3, 1'b1, 1'b0));
    total++; if (ex_ready !== 1'b0) $display("FAIL skid_full_ready: got %b want 0", ex_ready); else passed++;
    total++; if (mem_valid !== 1'b1 || M_ALUResult !== 32'hA)
      $display("FAIL skid_head: got v=%b %h want 1 0000000a", mem_valid, M_ALUResult);
    else passed++;
    @(negedge clk);
    total++; if (M_ALUResult !== 32'hA || ex_ready !== 1'b0)
      $display("FAIL skid_hold: got %h rdy=%b want 0000000a rdy=0", M_ALUResult, ex_ready);
    else passed++;
    set_in(1'b0, '0);
    mem_ready = 1'b1;
    @(negedge clk);
    total++; if (mem_valid !== 1'b1 || M_ALUResult !== 32'hB || M_DestReg !== 5'd2)
      $display("FAIL skid_second: got v=%b %h d=%0d want 1 0000000b d=2", mem_valid, M_ALUResult, M_DestReg);
    else passed++;
    @(negedge clk);
    total++; if (mem_valid !== 1'b0) $display("FAIL skid_drain: got %b want 0 (C must not be held)", mem_valid); else passed++;
  endtask

  task automatic test_flush();
    do_reset();
    mem_ready = 1'b0;
    set_in(1'b1, mk(32'h11, 5'd1, 1'b1, 1'b0));
    @(negedge clk);
    set_in(1'b1, mk(32'h22, 5'd2, 1'b1, 1'b0));
    @(negedge clk);
    flush = 1'b1; mem_ready = 1'b1;
    set_in(1'b1, mk(32'h33, 5'd3, 1'b1, 1'b0));
    @(negedge clk);
    flush = 1'b0; set_in(1'b0, '0);
    total++; if (mem_valid !== 1'b0 || ex_ready !== 1'b1)
      $display("FAIL flush_state: got v=%b rdy=%b want 0 1", mem_valid, ex_ready);
    else passed++;
    @(negedge clk);
    total++; if (mem_valid !== 1'b0) $display("FAIL flush_nocapture: got %b want 0", mem_valid); else passed++;
  endtask

  task automatic test_hazard();
    do_reset();
    mem_ready = 1'b0;
    set_in(1'b1, mk(32'h1234_5678, 5'd8, 1'b1, 1'b1));
    @(negedge clk);
    set_in(1'b0, '0); SrcA = 5'd1; SrcB = 5'd8;
    #1;
    total++; if (LoadUse !== 1'b1 || FwdB !== 1'b0)
      $display("FAIL hz_load: got lu=%b fb=%b want 1 0", LoadUse, FwdB);
    else passed++;
    do_reset();
    set_in(1'b1, mk(32'h1234_5678, 5'd8, 1'b1, 1'b0));
    @(negedge clk);
    set_in(1'b0, '0); SrcA = 5'd1; SrcB = 5'd8;
    #1;
    total++; if (LoadUse !== 1'b0 || FwdB !== FWD || FwdA !== 1'b0 || FwdData !== (FWD ? 32'h1234_5678 : 32'h0))
      $display("FAIL hz_fwd: got lu=%b fa=%b fb=%b fd=%h want 0 0 %b", LoadUse, FwdA, FwdB, FwdData, FWD);
    else passed++;
    do_reset();
    set_in(1'b1, mk(32'h9, 5'd0, 1'b1, 1'b0));
    @(negedge clk);
    set_in(1'b0, '0); SrcA = 5'd0; SrcB = 5'd0;
    #1;
    total++; if (FwdA !== 1'b0 || LoadUse !== 1'b0)
      $display("FAIL hz_r0: got fa=%b lu=%b want 0 0", FwdA, LoadUse);
    else passed++;
  endtask

  task automatic test_random();
    ent_t q[$];
    ent_t e;
    bit   acc, ret, lu, fa, fb;
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      e.alu = $urandom; e.sd = $urandom; e.dst = 5'($urandom_range(0, 3));
      {e.rw, e.mr, e.mw, e.m2r} = 4'($urandom);
      set_in(1'($urandom_range(0, 3) != 0), e);
      mem_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      reset     = ($urandom_range(0, 63) == 0);
      SrcA = 5'($urandom_range(0, 3)); SrcB = 5'($urandom_range(0, 3));
      #1;
      total++; if (mem_valid !== (q.size() > 0) || ex_ready !== (q.size() < 2))
        $display("FAIL rnd_flags@%0d: got v=%b rdy=%b want %b %b", cyc, mem_valid, ex_ready, q.size() > 0, q.size() < 2);
      else passed++;
      if (q.size() > 0) begin
        total++; if ({M_ALUResult, M_StoreData, M_DestReg, M_RegWrite, M_MemRead, M_MemWrite, M_MemToReg} !== q[0])
          $display("FAIL rnd_head@%0d: got %h/%h d=%0d want %h/%h d=%0d", cyc, M_ALUResult, M_StoreData, M_DestReg, q[0].alu, q[0].sd, q[0].dst);
        else passed++;
        lu = q[0].mr && q[0].dst != 0 && (q[0].dst == SrcA || q[0].dst == SrcB);
        fa = FWD && q[0].rw && !q[0].mr && q[0].dst != 0 && q[0].dst == SrcA;
        fb = FWD && q[0].rw && !q[0].mr && q[0].dst != 0 && q[0].dst == SrcB;
        total++; if (LoadUse !== lu || FwdA !== fa || FwdB !== fb || FwdData !== (FWD ? q[0].alu : 32'h0))
          $display("FAIL rnd_hazard@%0d: got lu=%b fa=%b fb=%b fd=%h want %b %b %b", cyc, LoadUse, FwdA, FwdB, FwdData, lu, fa, fb);
        else passed++;
      end else begin
        total++; if (LoadUse !== 1'b0 || FwdA !== 1'b0 || FwdB !== 1'b0)
          $display("FAIL rnd_empty_hazard@%0d: got lu=%b fa=%b fb=%b want 0 0 0", cyc, LoadUse, FwdA, FwdB);
        else passed++;
      end
      acc = ex_valid && q.size() < 2;
      ret = mem_ready && q.size() > 0;
      @(posedge clk);
      if (reset || flush) begin
        q.delete();
      end else begin
        if (ret) void'(q.pop_front());
        if (acc) q.push_back(e);
      end
    end
    @(negedge clk);
    reset = 1'b0; flush = 1'b0; set_in(1'b0, '0);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; mem_ready = 1'b0; SrcA = '0; SrcB = '0;
    set_in(1'b0, '0);
    test_reset();
    test_back_to_back();
    test_skid();
    test_flush();
    test_hazard();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
